// File: rtl/sif_pkg.sv
// Shared definitions for the SIF XA arbiter: FSM state encoding and default geometry.
`timescale 1ns/1ps

package sif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } sif_state_e;

    localparam int unsigned SIF_AW     = 8;
    localparam int unsigned SIF_DW     = 16;
    localparam int unsigned SIF_RD_LAT = 2;

endpackage

// File: rtl/sif_rr_arb2.sv
// Two-input round-robin selector; the last-grant register updates only when the
// caller accepts the current winner.
`timescale 1ns/1ps

module sif_rr_arb2 (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [1:0] req,
    input  logic       take,
    output logic       win,
    output logic       any
);

    logic last_q, last_d;

    always_comb begin
        any = |req;
        // On a tie the requester that did not win last time goes first.
        if (req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req[1];
        end
        last_d = take ? win : last_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sif_xa_arb.sv
// Two-requester arbiter onto a single SIF XA strobe interface, one access outstanding.
// Define SIF_XA_ARB_CNT_EN to add saturating per-requester grant counters (r0_cnt/r1_cnt).
`timescale 1ns/1ps

module sif_xa_arb
    import sif_pkg::*;
#(
    parameter int unsigned AW     = SIF_AW,
    parameter int unsigned DW     = SIF_DW,
    parameter int unsigned RD_LAT = SIF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd
`ifdef SIF_XA_ARB_CNT_EN
    ,
    output logic [15:0]   r0_cnt,
    output logic [15:0]   r1_cnt
`endif
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    sif_state_e    state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic          wr_s_q, wr_s_d;
    logic          rd_s_q, rd_s_d;

    logic          arb_any;
    logic          arb_win;
    logic          arb_take;

    sif_rr_arb2 u_arb (
        .clk   (clk),
        .rst_b (rst_b),
        .req   ({r1_req, r0_req}),
        .take  (arb_take),
        .win   (arb_win),
        .any   (arb_any)
    );

    assign arb_take = (state_q == IDLE) && arb_any;

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        wr_s_d   = 1'b0;
        rd_s_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Strobe, grant and held address are registered here so they
                // all appear together in the single ISSUE cycle.
                if (arb_any) begin
                    owner_d = arb_win;
                    we_d    = arb_win ? r1_we    : r0_we;
                    addr_d  = arb_win ? r1_addr  : r0_addr;
                    wdata_d = arb_win ? r1_wdata : r0_wdata;
                    gnt_d   = arb_win ? 2'b10 : 2'b01;
                    wr_s_d  = we_d;
                    rd_s_d  = ~we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = '0;
                state_d = we_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rdata_d  = xa_data_rd;
                    rvalid_d = owner_q ? 2'b10 : 2'b01;
                    state_d  = IDLE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            wr_s_q   <= 1'b0;
            rd_s_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            wr_s_q   <= wr_s_d;
            rd_s_q   <= rd_s_d;
        end
    end

    assign r0_gnt     = gnt_q[0];
    assign r1_gnt     = gnt_q[1];
    assign r0_rvalid  = rvalid_q[0];
    assign r1_rvalid  = rvalid_q[1];
    assign r0_rdata   = rdata_q;
    assign r1_rdata   = rdata_q;
    assign xa_wr_s    = wr_s_q;
    assign xa_rd_s    = rd_s_q;
    assign xa_addr    = addr_q;
    assign xa_data_wr = wdata_q;

`ifdef SIF_XA_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (arb_take && !arb_win && (cnt0_q != '1)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (arb_take && arb_win && (cnt1_q != '1)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign r0_cnt = cnt0_q;
    assign r1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_sif_xa_arb.sv
// Self-checking bench for sif_xa_arb: directed scenarios plus random traffic against a
// cycle-scheduled transaction model. Honours SIF_XA_ARB_CNT_EN for the counter ports.
`timescale 1ns/1ps

module tb_sif_xa_arb;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_b;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [7:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic        xa_wr_s, xa_rd_s;
    logic [7:0]  xa_addr;
    logic [15:0] xa_data_wr, xa_data_rd;
`ifdef SIF_XA_ARB_CNT_EN
    logic [15:0] r0_cnt, r1_cnt;
`endif

    sif_xa_arb #(.AW(8), .DW(16), .RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .r0_req     (r0_req),
        .r1_req     (r1_req),
        .r0_we      (r0_we),
        .r1_we      (r1_we),
        .r0_addr    (r0_addr),
        .r1_addr    (r1_addr),
        .r0_wdata   (r0_wdata),
        .r1_wdata   (r1_wdata),
        .r0_gnt     (r0_gnt),
        .r1_gnt     (r1_gnt),
        .r0_rvalid  (r0_rvalid),
        .r1_rvalid  (r1_rvalid),
        .r0_rdata   (r0_rdata),
        .r1_rdata   (r1_rdata),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_data_rd (xa_data_rd)
`ifdef SIF_XA_ARB_CNT_EN
        ,
        .r0_cnt     (r0_cnt),
        .r1_cnt     (r1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SIF slave: read-only contents, data valid only LAT cycles after the read strobe.
    function automatic logic [15:0] rom(input logic [7:0] a);
        return (a == 8'h22) ? 16'h1234 : {a ^ 8'h3C, ~a};
    endfunction

    logic [LAT-1:0] rd_hist;
    logic [7:0]     ah [LAT];
    logic [15:0]    junk;

    always @(posedge clk) begin
        rd_hist <= {rd_hist[LAT-2:0], xa_rd_s};
        ah[0]   <= xa_addr;
        for (int k = 1; k < LAT; k++) ah[k] <= ah[k-1];
        junk    <= 16'($urandom);
    end

    assign xa_data_rd = rd_hist[LAT-1] ? rom(ah[LAT-1]) : junk;

    // Requesters
    logic [1:0]  pend, keep;
    logic        rnd;
    logic        pw [2];
    logic [7:0]  pa [2];
    logic [15:0] pd [2];

    // Model
    int          total, bad, cyc, free_at, rv_due;
    int          gc [2];
    logic        last, rv_own;
    logic [15:0] rv_data, e_rdv;
    logic [1:0]  e_gnt, e_rv;
    logic        e_wr, e_rd;
    logic [7:0]  e_addr;
    logic [15:0] e_dw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        r0_req = pend[0]; r0_we = pw[0]; r0_addr = pa[0]; r0_wdata = pd[0];
        r1_req = pend[1]; r1_we = pw[1]; r1_addr = pa[1]; r1_wdata = pd[1];
    endtask

    task automatic issue(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
        pend[i] = 1'b1; pw[i] = we; pa[i] = a; pd[i] = d;
    endtask

    task automatic model_reset();
        free_at = 0; rv_due = -1; last = 1'b1; rv_own = 1'b0;
        rv_data = '0; e_rdv = '0; e_gnt = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0;
        e_addr = '0; e_dw = '0; gc[0] = 0; gc[1] = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},    {r1_gnt, r0_gnt}, 0);
        chk({tag, "_rvalid"}, {r1_rvalid, r0_rvalid}, 0);
        chk({tag, "_strobe"}, {xa_wr_s, xa_rd_s}, 0);
        chk({tag, "_addr"},   32'(xa_addr), 0);
        chk({tag, "_wdata"},  32'(xa_data_wr), 0);
        chk({tag, "_rdata"},  {r1_rdata, r0_rdata}, 0);
`ifdef SIF_XA_ARB_CNT_EN
        chk({tag, "_cnt"},    {r1_cnt, r0_cnt}, 0);
`endif
    endtask

    // One clock: check this cycle, update requesters, then schedule next cycle's outputs.
    task automatic step();
        logic w;
        @(negedge clk);
        cyc++;
        chk("r0_gnt", 32'(r0_gnt), 32'(e_gnt[0]));
        chk("r1_gnt", 32'(r1_gnt), 32'(e_gnt[1]));
        chk("xa_wr_s", 32'(xa_wr_s), 32'(e_wr));
        chk("xa_rd_s", 32'(xa_rd_s), 32'(e_rd));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(e_rv[0]));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(e_rv[1]));
        chk("xa_addr", 32'(xa_addr), 32'(e_addr));
        chk("xa_data_wr", 32'(xa_data_wr), 32'(e_dw));
        if (e_rv[0]) chk("r0_rdata", 32'(r0_rdata), 32'(e_rdv));
        if (e_rv[1]) chk("r1_rdata", 32'(r1_rdata), 32'(e_rdv));
`ifdef SIF_XA_ARB_CNT_EN
        chk("r0_cnt", 32'(r0_cnt), 32'(gc[0]));
        chk("r1_cnt", 32'(r1_cnt), 32'(gc[1]));
`endif
        for (int i = 0; i < 2; i++) begin
            if (e_gnt[i] && !keep[i]) pend[i] = 1'b0;
            if (rnd && !pend[i] && ($urandom_range(0, 2) == 0))
                issue(i, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
        end
        drive();

        e_gnt = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0;
        if (cyc + 1 == rv_due) begin
            e_rv[rv_own] = 1'b1;
            e_rdv        = rv_data;
        end
        if (cyc >= free_at && (pend != 2'b00)) begin
            w        = (pend == 2'b11) ? ~last : pend[1];
            last     = w;
            e_gnt[w] = 1'b1;
            e_wr     = pw[w];
            e_rd     = ~pw[w];
            e_addr   = pa[w];
            e_dw     = pd[w];
            if (gc[w] < 65535) gc[w]++;
            if (pw[w]) begin
                free_at = cyc + 2;
            end else begin
                free_at = cyc + LAT + 2;
                rv_due  = cyc + LAT + 2;
                rv_own  = w;
                rv_data = rom(pa[w]);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        #2 rst_b = 1'b0;
        pend = '0; keep = '0;
        drive();
        #1 chk_zero(tag);
        @(negedge clk);
        cyc++;
        #2 rst_b = 1'b1;
        model_reset();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; rnd = 1'b0;
        pend = '0; keep = '0;
        for (int i = 0; i < 2; i++) begin pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
        rst_b = 1'b0;
        drive();
        model_reset();
        #3 chk_zero("por");
        @(negedge clk);
        #2 rst_b = 1'b1;

        // Single write
        issue(0, 1'b1, 8'h10, 16'hBEEF);
        step();
        step();
        chk("wr_strobe", 32'(xa_wr_s), 1);
        chk("wr_addr", 32'(xa_addr), 32'h10);
        chk("wr_data", 32'(xa_data_wr), 32'hBEEF);
        chk("wr_gnt0", 32'(r0_gnt), 1);
        repeat (2) step();

        // Single read, rvalid three cycles after the read strobe
        issue(1, 1'b0, 8'h22, 16'h0);
        step();
        step();
        chk("rd_strobe", 32'(xa_rd_s), 1);
        repeat (3) step();
        chk("rd_rvalid1", 32'(r1_rvalid), 1);
        chk("rd_rdata1", 32'(r1_rdata), 32'h1234);
        repeat (2) step();

        // Tie after reset: alternating grants every other cycle
        do_reset("rst_a");
        issue(0, 1'b1, 8'hA0, 16'h1111);
        issue(1, 1'b1, 8'hB0, 16'h2222);
        keep = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tie_gnt0", 32'(r0_gnt), 32'(k % 2 == 0));
            chk("tie_gnt1", 32'(r1_gnt), 32'(k % 2 == 1));
            step();
            chk("tie_gap", 32'({r1_gnt, r0_gnt}), 0);
        end
        keep = '0; pend = '0;
        repeat (3) step();

        // Request arriving during RDWAIT waits for the read to complete
        issue(0, 1'b0, 8'h33, 16'h0);
        step();
        step();
        chk("rw_rdstrobe", 32'(xa_rd_s), 1);
        issue(1, 1'b1, 8'h44, 16'hCAFE);
        step();
        step();
        chk("rw_nowr", 32'(xa_wr_s), 0);
        step();
        chk("rw_rvalid0", 32'(r0_rvalid), 1);
        chk("rw_nowr2", 32'(xa_wr_s), 0);
        step();
        chk("rw_wr", 32'(xa_wr_s), 1);
        chk("rw_gnt1", 32'(r1_gnt), 1);
        chk("rw_addr", 32'(xa_addr), 32'h44);
        repeat (2) step();

        // Reset in the middle of a read
        issue(0, 1'b0, 8'h55, 16'h0);
        step();
        step();
        step();
        do_reset("rst_rd");
        repeat (4) step();
        issue(0, 1'b1, 8'h66, 16'h0A0A);
        issue(1, 1'b1, 8'h77, 16'h0B0B);
        step();
        step();
        chk("post_rst_gnt0", 32'(r0_gnt), 1);
        chk("post_rst_gnt1", 32'(r1_gnt), 0);
        repeat (6) step();

        // Random traffic against the model
        rnd = 1'b1;
        repeat (600) step();
        rnd = 1'b0;
        repeat (12) step();

        // Grant counting: 5 for r0, 3 for r1
        do_reset("rst_cnt");
        issue(0, 1'b1, 8'h01, 16'h0001);
        issue(1, 1'b1, 8'h02, 16'h0002);
        keep = 2'b11;
        repeat (12) step();
        keep = 2'b01;
        pend[1] = 1'b0;
        repeat (4) step();
        keep = '0; pend = '0;
        repeat (2) step();
`ifdef SIF_XA_ARB_CNT_EN
        chk("cnt_r0", 32'(r0_cnt), 5);
        chk("cnt_r1", 32'(r1_cnt), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sif_xa_arb.md
SIF_XA_ARB -- requirements
Module: sif_xa_arb

Interface
REQ-001 The block SHALL have parameter AW, default 8, the XA address width.
REQ-002 The block SHALL have parameter DW, default 16, the XA data width.
REQ-003 The block SHALL have parameter RD_LAT, default 2 (legal 1..7), cycles from xa_rd_s to valid xa_data_rd.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The ports SHALL be, in this order:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- r0_req / r1_req  in  1  access request, held until grant
- r0_we / r1_we  in  1  1 = write, 0 = read
- r0_addr / r1_addr  in  AW  access address
- r0_wdata / r1_wdata  in  DW  write data
- r0_gnt / r1_gnt  out  1  one-cycle grant pulse
- r0_rvalid / r1_rvalid  out  1  one-cycle read-data-valid pulse
- r0_rdata / r1_rdata  out  DW  read data, valid with rvalid
- xa_wr_s  out  1  SIF write strobe
- xa_rd_s  out  1  SIF read strobe
- xa_addr  out  AW  SIF address
- xa_data_wr  out  DW  SIF write data
- xa_data_rd  in  DW  SIF read data

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE and RDWAIT.
- IDLE -> ISSUE when either req = 1.
- ISSUE -> IDLE for a write; ISSUE -> RDWAIT for a read.
- RDWAIT -> IDLE after RD_LAT cycles.
REQ-007 In IDLE, the block SHALL select the winner: a single requester wins outright; on a tie, the requester not granted last wins (round-robin).
REQ-008 Selection SHALL register the winner's we, addr and wdata into internal holding registers.
REQ-009 In ISSUE, exactly one strobe SHALL be driven high for exactly one cycle: xa_wr_s if we = 1, otherwise xa_rd_s.
REQ-010 In ISSUE, xa_addr and xa_data_wr SHALL carry the held values, and the winner's gnt SHALL pulse high.
REQ-011 Grant latency SHALL be exactly one cycle: req sampled in IDLE at cycle N, then strobe and gnt at cycle N+1.
REQ-012 For a read, the block SHALL capture xa_data_rd RD_LAT cycles after the xa_rd_s cycle and pulse the owner's rvalid in the following cycle, with rdata held until the next read completes.
REQ-013 xa_addr and xa_data_wr SHALL hold their last values when not strobing, and both strobes SHALL be low outside ISSUE.
REQ-014 The block SHALL ignore requests arriving in ISSUE or RDWAIT until return to IDLE, so at most one access is outstanding.
REQ-015 A requester SHALL be able to re-request the cycle after gnt or rvalid; back-to-back writes therefore issue every 2 cycles.
REQ-016 The block SHALL never assert r0_gnt and r1_gnt, or xa_wr_s and xa_rd_s, in the same cycle.

Reset
REQ-017 Asserting rst_b low SHALL immediately force the following values:
- State = IDLE, all gnt, rvalid and strobes = 0.
- xa_addr, xa_data_wr and rdata = 0.
- Round-robin pointer = "r1 last", so r0 wins the first tie.
REQ-018 Reset during RDWAIT SHALL abort the read without producing an rvalid pulse.

Configuration
REQ-019 With SIF_XA_ARB_CNT_EN defined, the block SHALL add outputs r0_cnt and r1_cnt (16 bits each), counting grants per requester, saturating at 0xFFFF and cleared by reset.
REQ-020 Without SIF_XA_ARB_CNT_EN, those ports and their counters SHALL be absent.

Structure
REQ-021 Package sif_pkg SHALL hold the FSM state enum and the default AW, DW and RD_LAT constants.
REQ-022 Round-robin winner selection SHALL be the sub-module sif_rr_arb2 (2-input round-robin selector with a last-grant register); everything else stays in sif_xa_arb.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single write: r0 writes addr 0x10, data 0xBEEF -> 1 cycle later xa_wr_s = 1, xa_addr = 0x10, xa_data_wr = 0xBEEF and r0_gnt = 1 in the same cycle.
- Single read, RD_LAT = 2: r1 reads 0x22, model returns 0x1234 -> r1_rvalid = 1 and r1_rdata = 0x1234 exactly 3 cycles after xa_rd_s.
- Tie after reset: both write continuously -> grants r0, r1, r0, r1, one every 2 cycles, never both.
- Request during RDWAIT: r0 reads, r1 requests a write mid-wait -> xa_wr_s only after r0_rvalid, with no strobe overlap.
- Reset mid-read: rst_b low during RDWAIT -> no rvalid, all outputs 0, next tie grants r0.
- SIF_XA_ARB_CNT_EN build: 5 r0 grants and 3 r1 grants -> r0_cnt = 5, r1_cnt = 3.
